// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline hazard, MDU busy and exception-flush controller
//
// Purpose:
//   Produces the stall/bubble/flush/redirect controls for a 5-stage pipeline:
//     - load-use hazard between the EX load and the ID instruction
//     - MDU hazard while a multiply/divide is counting (or starting)
//     - exception sequence RUN -> FLUSH -> REDIRECT -> RUN
//
// Optional feature (macro PIPE_CTRL_STATS_EN):
//   adds output stall_cnt, a 32-bit wrapping count of cycles with stall=1.
//
// Ports:
//   clk            in   rising-edge clock
//   reset          in   synchronous, active-high
//   id_rs, id_rt   in   [4:0] ID source registers
//   id_use_rs/rt   in   ID instruction reads rs / rt
//   id_is_md       in   ID instruction is an MDU instruction
//   ex_a3          in   [4:0] EX destination register
//   ex_is_load     in   EX instruction is a load
//   md_start       in   EX instruction starts an MDU operation
//   md_is_div      in   that MDU operation is a divide
//   exc_req        in   exception/interrupt taken at MEM this cycle
//   stall          out  freeze PC and IF/ID
//   flush_idex     out  bubble into ID/EX
//   flush_all      out  clear IF/ID, ID/EX, EX/MEM, MEM/WB
//   pc_to_handler  out  load PC with handler address
//   md_busy        out  MDU operation in progress
//   stall_cnt      out  [31:0] stall cycle count (PIPE_CTRL_STATS_EN only)

module pipe_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic       id_is_md,
  input  logic [4:0] ex_a3,
  input  logic       ex_is_load,
  input  logic       md_start,
  input  logic       md_is_div,
  input  logic       exc_req,
  output logic       stall,
  output logic       flush_idex,
  output logic       flush_all,
  output logic       pc_to_handler,
  output logic       md_busy
`ifdef PIPE_CTRL_STATS_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  localparam logic [3:0] MD_MULT_CYC = 4'd5;
  localparam logic [3:0] MD_DIV_CYC  = 4'd10;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_REDIRECT = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] md_cnt_q, md_cnt_d;

  logic lu;
  logic mh;
  logic md_accept;

  // Load-use: register 0 is never a real dependency.
  always_comb begin
    lu = ex_is_load && (ex_a3 != 5'd0) &&
         ((id_use_rs && (id_rs == ex_a3)) || (id_use_rt && (id_rt == ex_a3)));
  end

  assign md_busy = (md_cnt_q != 4'd0);

  // md_start counts as a hazard in its own cycle so the MDU instruction in
  // ID cannot slip past the operation that is being launched.
  assign mh = id_is_md && (md_busy || md_start);

  // Exception FSM: next state and flush/redirect outputs.
  always_comb begin
    state_d       = state_q;
    flush_all     = 1'b0;
    pc_to_handler = 1'b0;
    stall         = 1'b0;
    flush_idex    = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (exc_req) begin
          flush_all = 1'b1;
          state_d   = ST_FLUSH;
        end else begin
          // Hazards only matter when no exception is flushing the pipe.
          stall      = lu || mh;
          flush_idex = lu || mh;
        end
      end
      ST_FLUSH: begin
        flush_all = 1'b1;
        state_d   = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        pc_to_handler = 1'b1;
        state_d       = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // An operation being flushed never starts; a start while counting is
  // dropped, which only happens if the ID-side hazard was bypassed.
  assign md_accept = md_start && !md_busy && !flush_all;

  always_comb begin
    md_cnt_d = md_cnt_q;
    if (md_busy) begin
      md_cnt_d = md_cnt_q - 4'd1;
    end else if (md_accept) begin
      md_cnt_d = md_is_div ? MD_DIV_CYC : MD_MULT_CYC;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_RUN;
      md_cnt_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

`ifdef PIPE_CTRL_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Natural 32-bit wrap from all-ones back to zero.
  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'd0, stall};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - self-checking bench for pipe_ctrl
module tb_pipe_ctrl;

  logic       clk;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_a3;
  logic       id_use_rs, id_use_rt, id_is_md;
  logic       ex_is_load, md_start, md_is_div, exc_req;
  logic       stall, flush_idex, flush_all, pc_to_handler, md_busy;
`ifdef PIPE_CTRL_STATS_EN
  logic [31:0] stall_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model: exception phase (0 run, 1 flush, 2 redirect) and
  // remaining MDU cycles, advanced once per clock.
  int          m_phase;
  int          m_md;
  logic [31:0] m_stalls;

  logic       e_lu, e_flush, e_busy, e_mh, e_stall, e_pc;
  logic [4:0] exp_vec, act_vec;

  pipe_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_use_rs     (id_use_rs),
    .id_use_rt     (id_use_rt),
    .id_is_md      (id_is_md),
    .ex_a3         (ex_a3),
    .ex_is_load    (ex_is_load),
    .md_start      (md_start),
    .md_is_div     (md_is_div),
    .exc_req       (exc_req),
    .stall         (stall),
    .flush_idex    (flush_idex),
    .flush_all     (flush_all),
    .pc_to_handler (pc_to_handler),
    .md_busy       (md_busy)
`ifdef PIPE_CTRL_STATS_EN
    ,
    .stall_cnt     (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_eval();
    e_lu    = ex_is_load && (ex_a3 != 0) &&
              ((id_use_rs && id_rs == ex_a3) || (id_use_rt && id_rt == ex_a3));
    e_flush = (m_phase == 0 && exc_req) || (m_phase == 1);
    e_busy  = (m_md > 0);
    e_mh    = id_is_md && (e_busy || md_start);
    e_stall = (m_phase == 0) && !e_flush && (e_lu || e_mh);
    e_pc    = (m_phase == 2);
    exp_vec = {e_stall, e_stall, e_flush, e_pc, e_busy};
  endtask

  task automatic settle();
    #1;
    model_eval();
    act_vec = {stall, flush_idex, flush_all, pc_to_handler, md_busy};
  endtask

  task automatic tick();
    @(posedge clk);
    model_eval();
    if (reset) begin
      m_phase  = 0;
      m_md     = 0;
      m_stalls = 0;
    end else begin
      if (e_stall) m_stalls = m_stalls + 1;
      if (m_md > 0) m_md = m_md - 1;
      else if (md_start && !e_flush) m_md = md_is_div ? 10 : 5;
      case (m_phase)
        0: if (exc_req) m_phase = 1;
        1: m_phase = 2;
        default: m_phase = 0;
      endcase
    end
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    id_rs = 0; id_rt = 0; ex_a3 = 0;
    id_use_rs = 0; id_use_rt = 0; id_is_md = 0;
    ex_is_load = 0; md_start = 0; md_is_div = 0; exc_req = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    settle();
    checks++;
    if (act_vec !== 5'b00000) begin
      failures++;
      $display("FAIL reset_outputs actual=%b required=%b", act_vec, 5'b00000);
    end
`ifdef PIPE_CTRL_STATS_EN
    checks++;
    if (stall_cnt !== 32'd0) begin
      failures++;
      $display("FAIL reset_stall_cnt actual=%0d required=0", stall_cnt);
    end
`endif
  endtask

  task automatic test_load_use();
    logic [4:0] r;
    clear_inputs();
    ex_is_load = 1; ex_a3 = 8; id_use_rs = 1; id_rs = 8;
    settle();
    checks++;
    if ({stall, flush_idex} !== 2'b11) begin
      failures++;
      $display("FAIL lu_rs_match actual=%b required=11", {stall, flush_idex});
    end
    ex_a3 = 0; id_rs = 0;
    settle();
    checks++;
    if ({stall, flush_idex} !== 2'b00) begin
      failures++;
      $display("FAIL lu_r0 actual=%b required=00", {stall, flush_idex});
    end
    ex_a3 = 17; id_rs = 3; id_use_rt = 1; id_rt = 17;
    settle();
    checks++;
    if ({stall, flush_idex} !== 2'b11) begin
      failures++;
      $display("FAIL lu_rt_match actual=%b required=11", {stall, flush_idex});
    end
    id_use_rt = 0;
    settle();
    checks++;
    if ({stall, flush_idex} !== 2'b00) begin
      failures++;
      $display("FAIL lu_rt_unused actual=%b required=00", {stall, flush_idex});
    end
    for (int i = 0; i < 60; i++) begin
      r = 5'($urandom_range(0, 3));
      ex_a3 = r;
      ex_is_load = 1'($urandom);
      id_rs = 5'($urandom_range(0, 3));
      id_rt = 5'($urandom_range(0, 3));
      id_use_rs = 1'($urandom);
      id_use_rt = 1'($urandom);
      settle();
      checks++;
      if (act_vec !== exp_vec) begin
        failures++;
        $display("FAIL lu_random i=%0d actual=%b required=%b", i, act_vec, exp_vec);
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic run_mdu(input logic is_div, input int want);
    int busy_n, stall_n;
    clear_inputs();
    md_start = 1; md_is_div = is_div; id_is_md = 1;
    settle();
    checks++;
    if (stall !== 1'b1 || md_busy !== 1'b0) begin
      failures++;
      $display("FAIL mdu_start_cycle div=%0d actual=%b%b required=10", is_div, stall, md_busy);
    end
    tick();
    md_start = 0;
    busy_n = 0; stall_n = 0;
    for (int i = 0; i < 14; i++) begin
      settle();
      checks++;
      if (act_vec !== exp_vec) begin
        failures++;
        $display("FAIL mdu_cycle div=%0d i=%0d actual=%b required=%b", is_div, i, act_vec, exp_vec);
      end
      if (md_busy === 1'b1) busy_n++;
      if (stall === 1'b1) stall_n++;
      tick();
    end
    checks++;
    if (busy_n != want || stall_n != want) begin
      failures++;
      $display("FAIL mdu_length div=%0d actual busy=%0d stall=%0d required=%0d", is_div, busy_n, stall_n, want);
    end
    clear_inputs();
  endtask

  task automatic test_mdu();
    run_mdu(1'b0, 5);
    run_mdu(1'b1, 10);
  endtask

  task automatic test_exception();
    logic [4:0] want [4];
    // stall, flush_idex, flush_all, pc_to_handler, md_busy per cycle T..T+3
    want[0] = 5'b00100; want[1] = 5'b00100; want[2] = 5'b00010; want[3] = 5'b11000;
    clear_inputs();
    ex_is_load = 1; ex_a3 = 5; id_use_rs = 1; id_rs = 5;
    for (int i = 0; i < 4; i++) begin
      exc_req = (i == 0);
      settle();
      checks++;
      if (act_vec !== want[i] || act_vec !== exp_vec) begin
        failures++;
        $display("FAIL exc_seq T+%0d actual=%b required=%b", i, act_vec, want[i]);
      end
      tick();
    end
    // exc_req held through FLUSH/REDIRECT must not re-enter early.
    want[0] = 5'b00100; want[1] = 5'b00100; want[2] = 5'b00010; want[3] = 5'b00100;
    clear_inputs();
    exc_req = 1;
    for (int i = 0; i < 4; i++) begin
      settle();
      checks++;
      if (act_vec !== want[i] || act_vec !== exp_vec) begin
        failures++;
        $display("FAIL exc_held T+%0d actual=%b required=%b", i, act_vec, want[i]);
      end
      tick();
    end
    clear_inputs();
    tick();
    tick();
  endtask

  task automatic test_exc_mdu();
    int busy_n;
    clear_inputs();
    exc_req = 1; md_start = 1; md_is_div = 1;
    tick();
    clear_inputs();
    settle();
    checks++;
    if (md_busy !== 1'b0) begin
      failures++;
      $display("FAIL exc_blocks_md_start actual=%b required=0", md_busy);
    end
    tick();
    tick();
    md_start = 1; md_is_div = 1;
    tick();
    md_start = 0;
    for (int i = 0; i < 4; i++) tick();
    exc_req = 1;
    settle();
    checks++;
    if (md_busy !== 1'b1 || flush_all !== 1'b1) begin
      failures++;
      $display("FAIL exc_at_count6 actual=%b%b required=11", md_busy, flush_all);
    end
    tick();
    exc_req = 0;
    busy_n = 0;
    for (int i = 0; i < 8; i++) begin
      settle();
      checks++;
      if (act_vec !== exp_vec) begin
        failures++;
        $display("FAIL exc_md_continue i=%0d actual=%b required=%b", i, act_vec, exp_vec);
      end
      if (md_busy === 1'b1) busy_n++;
      tick();
    end
    checks++;
    if (busy_n != 5) begin
      failures++;
      $display("FAIL exc_md_remaining actual=%0d required=5", busy_n);
    end
  endtask

  task automatic test_reset_mid_flush();
    clear_inputs();
    exc_req = 1;
    tick();
    exc_req = 0;
    reset = 1;
    tick();
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      settle();
      checks++;
      if (act_vec !== 5'b00000) begin
        failures++;
        $display("FAIL reset_in_flush i=%0d actual=%b required=00000", i, act_vec);
      end
      tick();
    end
    md_start = 1; md_is_div = 1;
    tick();
    md_start = 0;
    tick();
    reset = 1;
    tick();
    reset = 0;
    settle();
    checks++;
    if (md_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_mdu actual=%b required=0", md_busy);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      reset      = ($urandom_range(0, 99) == 0);
      id_rs      = 5'($urandom_range(0, 3));
      id_rt      = 5'($urandom_range(0, 3));
      ex_a3      = 5'($urandom_range(0, 3));
      id_use_rs  = 1'($urandom);
      id_use_rt  = 1'($urandom);
      ex_is_load = 1'($urandom);
      id_is_md   = ($urandom_range(0, 2) == 0);
      md_start   = ($urandom_range(0, 5) == 0);
      md_is_div  = 1'($urandom);
      exc_req    = ($urandom_range(0, 14) == 0);
      settle();
      checks++;
      if (act_vec !== exp_vec) begin
        failures++;
        $display("FAIL random i=%0d actual=%b required=%b", i, act_vec, exp_vec);
      end
`ifdef PIPE_CTRL_STATS_EN
      checks++;
      if (stall_cnt !== m_stalls) begin
        failures++;
        $display("FAIL random_stall_cnt i=%0d actual=%0d required=%0d", i, stall_cnt, m_stalls);
      end
`endif
      tick();
    end
    reset = 0;
    clear_inputs();
  endtask

`ifdef PIPE_CTRL_STATS_EN
  task automatic test_stats();
    do_reset();
    ex_is_load = 1; ex_a3 = 9; id_use_rt = 1; id_rt = 9;
    for (int i = 0; i < 3; i++) tick();
    clear_inputs();
    md_start = 1; md_is_div = 1;
    tick();
    md_start = 0; id_is_md = 1;
    for (int i = 0; i < 14; i++) tick();
    clear_inputs();
    settle();
    checks++;
    if (stall_cnt !== 32'd13 || stall_cnt !== m_stalls) begin
      failures++;
      $display("FAIL stats_13 actual=%0d required=13", stall_cnt);
    end
  endtask
`endif

  initial begin
    m_phase  = 0;
    m_md     = 0;
    m_stalls = 0;
    reset    = 1'b1;
    clear_inputs();
    @(negedge clk);
    test_reset();
    test_load_use();
    test_mdu();
    test_exception();
    test_exc_mdu();
    test_reset_mid_flush();
    test_random();
`ifdef PIPE_CTRL_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have reset  input  1  synchronous, active-high; all state cleared on the clk edge where it is 1.
REQ-003 SHALL have id_rs, id_rt  input  5 each  source registers of the instruction in ID.
REQ-004 SHALL have id_use_rs, id_use_rt  input  1 each  ID instruction reads rs / rt this cycle.
REQ-005 SHALL have id_is_md  input  1  ID instruction is mult/div/mfhi/mflo/mthi/mtlo.
REQ-006 SHALL have ex_a3  input  5  destination register of EX instruction; ex_is_load  input  1  EX instruction is a load.
REQ-007 SHALL have md_start  input  1  EX instruction starts an MDU operation; md_is_div  input  1  that operation is a divide.
REQ-008 SHALL have exc_req  input  1  exception/interrupt taken at the MEM stage this cycle.
REQ-009 SHALL have stall  output  1  freeze PC and IF/ID register; flush_idex  output  1  bubble into ID/EX.
REQ-010 SHALL have flush_all  output  1  clear IF/ID, ID/EX, EX/MEM and MEM/WB (drives their strange input); pc_to_handler  output  1  load PC with handler address.
REQ-011 SHALL have md_busy  output  1  MDU operation in progress.

Function
REQ-012 Load-use: lu = ex_is_load & (ex_a3 != 0) & ((id_use_rs & id_rs == ex_a3) | (id_use_rt & id_rt == ex_a3)), combinational.
REQ-013 MDU counter: 4-bit md_cnt; on md_start (accepted) loads 5 (mult) or 10 (div); decrements by 1 per cycle while nonzero; md_busy = (md_cnt != 0).
REQ-014 md_start arriving while md_cnt != 0 SHALL be ignored (cannot occur when REQ-015 holds; no reload).
REQ-015 MDU hazard: mh = id_is_md & (md_busy | md_start).
REQ-016 In RUN: stall = flush_idex = lu | mh; both combinational, zero latency.
REQ-017 Exception FSM states RUN, FLUSH, REDIRECT; RUN->FLUSH on exc_req; FLUSH->REDIRECT unconditionally; REDIRECT->RUN unconditionally.
REQ-018 flush_all SHALL be 1 combinationally in RUN when exc_req=1, and 1 throughout FLUSH; 0 otherwise.
REQ-019 pc_to_handler SHALL be 1 only in REDIRECT, exactly one cycle.
REQ-020 Whenever flush_all=1 or state=REDIRECT: stall=0, flush_idex=0 (exception overrides hazards).
REQ-021 md_start coincident with flush_all=1 SHALL NOT load md_cnt; an operation already counting SHALL continue to completion.
REQ-022 exc_req in FLUSH or REDIRECT SHALL be ignored (no re-entry).
REQ-023 md_cnt reaching 0 and a new md_start in the same cycle SHALL load the new value.

Reset
REQ-024 On reset: state=RUN, md_cnt=0; hence stall=0, flush_idex=0, flush_all=0, pc_to_handler=0, md_busy=0 (given exc_req=0, md_start=0, lu=0).
REQ-025 Reset mid-FLUSH/REDIRECT or mid-MDU SHALL abort the sequence; pc_to_handler not asserted after reset.

Configuration
REQ-026 Macro PIPE_CTRL_STATS_EN: when defined, adds output stall_cnt (32-bit) counting cycles with stall=1, cleared on reset, wraps at 2^32-1 -> 0; when undefined, port and counter do not exist and behaviour is otherwise identical.

Verification
REQ-027 ex_is_load=1, ex_a3=8, id_use_rs=1, id_rs=8 -> stall=flush_idex=1 same cycle; ex_a3=0 -> both 0.
REQ-028 md_start=1, md_is_div=0 then id_is_md=1 held -> stall=1 on start cycle plus 5 cycles, md_busy 1 for exactly 5 cycles; div -> 10.
REQ-029 exc_req=1 one cycle with lu=1 -> flush_all=1 two cycles (T, T+1), stall=0, pc_to_handler=1 at T+2 only.
REQ-030 exc_req=1 with md_start=1 -> md_busy stays 0; exc_req during active div at count 6 -> count continues to 0.
REQ-031 reset asserted in FLUSH -> next cycle state RUN, all outputs 0, no pc_to_handler.
REQ-032 With PIPE_CTRL_STATS_EN: 3 load-use stalls then 10 div stalls -> stall_cnt=13.
